// File: rtl/wb_burst_io_unit.sv
// Wishbone burst mover between a row-organised data memory and a bus: each
// memory row holds COMPONENTS words that travel as consecutive bus words.
module wb_burst_io_unit #(
    parameter int WIDTH      = 32,
    parameter int COMPONENTS = 3,
    parameter int ADDR_W     = 7,
    parameter int CNT_W      = 8
) (
    input  logic                        Clock,
    input  logic                        Reset,
    input  logic                        iStart,
    input  logic                        iWrite,
    input  logic                        iAdrType,
    input  logic [WIDTH-1:0]            iAdrImm,
    input  logic [ADDR_W-1:0]           iAdrPointer,
    input  logic [ADDR_W-1:0]           iMemAddr,
    input  logic [CNT_W-1:0]            iRowCount,
    output logic                        oBusy,
    output logic                        oDone,
    output logic                        oError,
    output logic [ADDR_W-1:0]           oMemReadAddr,
    input  logic [COMPONENTS*WIDTH-1:0] iMemReadData,
    output logic [ADDR_W-1:0]           oMemWriteAddr,
    output logic                        oMemWriteEnable,
    output logic [COMPONENTS*WIDTH-1:0] oMemWriteData,
    output logic [WIDTH-1:0]            ADR_O,
    output logic [WIDTH-1:0]            DAT_O,
    input  logic [WIDTH-1:0]            DAT_I,
    output logic                        WE_O,
    output logic                        STB_O,
    output logic                        CYC_O,
    input  logic                        ACK_I,
    input  logic                        ERR_I,
    output logic [1:0]                  TGC_O
);
    localparam int CW = (COMPONENTS > 1) ? $clog2(COMPONENTS) : 1;
    localparam logic [CW-1:0] LAST_COMP = CW'(COMPONENTS - 1);

    typedef enum logic [2:0] {IDLE, FETCH_ADR, MEM_RD, BUS, MEM_WR, DONE} state_t;

    state_t                    state_reg, state_next;
    // phase_reg=1 marks the cycle in which the memory returns the addressed row
    logic                      phase_reg;
    logic                      cyc_reg;
    logic                      error_reg;
    logic                      write_reg;
    logic [ADDR_W-1:0]         ptr_reg;
    logic [ADDR_W-1:0]         row_reg;
    logic [CNT_W-1:0]          rows_reg;
    logic [WIDTH-1:0]          adr_reg;
    logic [CW-1:0]             comp_reg;
    logic [WIDTH-1:0]          row_buf [COMPONENTS];
    logic [COMPONENTS*WIDTH-1:0] packed_row;
    logic                      last_comp;
    logic                      last_row;
    logic                      busy;

    generate
        for (genvar gi = 0; gi < COMPONENTS; gi++) begin : g_pack
            assign packed_row[gi*WIDTH +: WIDTH] = row_buf[gi];
        end
    endgenerate

    assign last_comp = (comp_reg == LAST_COMP);
    assign last_row  = (rows_reg == CNT_W'(1));
    assign busy      = (state_reg != IDLE) && (state_reg != DONE);

    always_ff @(posedge Clock) begin
        if (Reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next      = state_reg;
        oBusy           = busy;
        oDone           = (state_reg == DONE);
        oError          = error_reg;
        STB_O           = (state_reg == BUS);
        CYC_O           = cyc_reg;
        WE_O            = busy & write_reg;
        TGC_O           = busy ? {1'b0, write_reg} : 2'b00;
        ADR_O           = '0;
        DAT_O           = '0;
        oMemReadAddr    = '0;
        oMemWriteAddr   = '0;
        oMemWriteEnable = 1'b0;
        oMemWriteData   = '0;
        case (state_reg)
            IDLE: begin
                if (iStart) begin
                    if (iRowCount == '0) state_next = DONE;
                    else if (!iAdrType)  state_next = FETCH_ADR;
                    else if (iWrite)     state_next = MEM_RD;
                    else                 state_next = BUS;
                end
            end
            FETCH_ADR: begin
                if (!phase_reg) oMemReadAddr = ptr_reg;
                else            state_next = write_reg ? MEM_RD : BUS;
            end
            MEM_RD: begin
                if (!phase_reg) oMemReadAddr = row_reg;
                else            state_next = BUS;
            end
            BUS: begin
                ADR_O = adr_reg;
                if (write_reg) DAT_O = row_buf[comp_reg];
                if (ERR_I) begin
                    state_next = DONE;
                end else if (ACK_I && last_comp) begin
                    if (!write_reg)    state_next = MEM_WR;
                    else if (last_row) state_next = DONE;
                    else               state_next = MEM_RD;
                end
            end
            MEM_WR: begin
                oMemWriteEnable = 1'b1;
                oMemWriteAddr   = row_reg;
                oMemWriteData   = packed_row;
                state_next      = last_row ? DONE : BUS;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            phase_reg <= 1'b0;
            cyc_reg   <= 1'b0;
            error_reg <= 1'b0;
            write_reg <= 1'b0;
            ptr_reg   <= '0;
            row_reg   <= '0;
            rows_reg  <= '0;
            adr_reg   <= '0;
            comp_reg  <= '0;
            for (int k = 0; k < COMPONENTS; k++) row_buf[k] <= '0;
        end else begin
            phase_reg <= ((state_reg == FETCH_ADR) || (state_reg == MEM_RD)) && !phase_reg;
            // The bus cycle stays open across memory gaps until the transfer ends
            if (state_next == BUS)       cyc_reg <= 1'b1;
            else if (state_next == DONE) cyc_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (iStart) begin
                        write_reg <= iWrite;
                        ptr_reg   <= iAdrPointer;
                        row_reg   <= iMemAddr;
                        rows_reg  <= iRowCount;
                        adr_reg   <= iAdrImm;
                        comp_reg  <= '0;
                        error_reg <= 1'b0;
                    end
                end
                FETCH_ADR: begin
                    if (phase_reg) adr_reg <= iMemReadData[WIDTH-1:0];
                end
                MEM_RD: begin
                    if (phase_reg)
                        for (int k = 0; k < COMPONENTS; k++)
                            row_buf[k] <= iMemReadData[k*WIDTH +: WIDTH];
                end
                BUS: begin
                    if (ERR_I) begin
                        error_reg <= 1'b1;
                    end else if (ACK_I) begin
                        adr_reg <= adr_reg + 1'b1;
                        if (!write_reg) row_buf[comp_reg] <= DAT_I;
                        if (last_comp) begin
                            comp_reg <= '0;
                            if (write_reg) begin
                                row_reg  <= row_reg + 1'b1;
                                rows_reg <= rows_reg - 1'b1;
                            end
                        end else begin
                            comp_reg <= comp_reg + 1'b1;
                        end
                    end
                end
                MEM_WR: begin
                    row_reg  <= row_reg + 1'b1;
                    rows_reg <= rows_reg - 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/wb_burst_io_unit.md
WB_BURST_IO_UNIT -- requirements
Module: wb_burst_io_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32: bus word and component width.
REQ-002 SHALL have parameter COMPONENTS, default 3: words per data-memory row (X, Y, Z...).
REQ-003 SHALL have parameter ADDR_W, default 7: data-memory row address width.
REQ-004 SHALL have parameter CNT_W, default 8: row-count width.
REQ-005 SHALL use a single clock; reset is synchronous and active-high: Clock in 1 (rising edge); Reset in 1 (synchronous, active-high).
REQ-006 SHALL have the following command ports:
- iStart in 1: start command.
- iWrite in 1: 1 = memory-to-bus, 0 = bus-to-memory.
- iAdrType in 1: 1 = immediate, 0 = pointer.
- iAdrImm in WIDTH: immediate bus start address.
- iAdrPointer in ADDR_W: row whose X component holds the bus start address.
- iMemAddr in ADDR_W: first source/destination row.
- iRowCount in CNT_W: rows to transfer.
REQ-007 SHALL have the following status and memory ports:
- oBusy out 1; oDone out 1 (one-cycle pulse); oError out 1.
- oMemReadAddr out ADDR_W; iMemReadData in COMPONENTS*WIDTH.
- oMemWriteAddr out ADDR_W; oMemWriteEnable out 1; oMemWriteData out COMPONENTS*WIDTH.
REQ-008 SHALL have the following Wishbone master ports: ADR_O out WIDTH; DAT_O out WIDTH; DAT_I in WIDTH; WE_O out 1; STB_O out 1; CYC_O out 1; ACK_I in 1; ERR_I in 1; TGC_O out 2.

Function
REQ-009 SHALL implement states IDLE, FETCH_ADR, MEM_RD, BUS, MEM_WR, DONE.
REQ-010 IDLE: when iStart=1, SHALL latch all command inputs, clear oError, and assert oBusy from the next cycle.
REQ-011 IDLE, start with iRowCount=0: SHALL go to DONE with no bus or memory activity.
REQ-012 iStart SHALL be ignored in every state other than IDLE.
REQ-013 Row addressing: memory read data SHALL be valid one cycle after oMemReadAddr is driven. Component k SHALL occupy iMemReadData/oMemWriteData bits [k*WIDTH +: WIDTH]; X is k=0.
REQ-014 Bus start address:
- iAdrType=1: SHALL be iAdrImm, with no FETCH_ADR.
- iAdrType=0: FETCH_ADR SHALL drive oMemReadAddr=iAdrPointer for one cycle, then latch the X component as the bus start address.
REQ-015 Memory-to-bus (iWrite=1): MEM_RD SHALL drive the current row address for one cycle, latch the row, then go to BUS.
REQ-016 Bus-to-memory (iWrite=0): the first row SHALL enter BUS directly after the address phase.
REQ-017 BUS: STB_O SHALL be 1 while waiting for ACK_I. ADR_O SHALL be the current word address. WE_O SHALL equal iWrite. DAT_O SHALL be the current component when writing, else 0.
REQ-018 On ACK_I=1 in BUS, SHALL:
- increment the bus word address by 1, wrapping modulo 2^WIDTH;
- when reading, store DAT_I into component slot k;
- advance k.
REQ-019 After ACK of component COMPONENTS-1:
- writing: SHALL go to MEM_RD for the next row, or to DONE after the last row;
- reading: SHALL go to MEM_WR.
REQ-020 MEM_WR: SHALL assert oMemWriteEnable for exactly one cycle with the current row address and the assembled row, then go to BUS for the next row or to DONE.
REQ-021 The row address SHALL increment by 1 per row, wrapping modulo 2^ADDR_W.
REQ-022 CYC_O SHALL be 1 from the first BUS cycle until DONE is entered, including MEM_RD and MEM_WR gaps. STB_O SHALL be 0 outside BUS.
REQ-023 TGC_O SHALL be 2'b01 for a write transfer and 2'b00 for a read transfer, held constant while oBusy=1.
REQ-024 ERR_I=1 in BUS, including simultaneously with ACK_I, SHALL:
- abort with no further bus or memory writes;
- set oError, held until the next accepted start;
- go to DONE.
A partially assembled row SHALL NOT be written.
REQ-025 DONE: SHALL pulse oDone=1 for one cycle, deassert oBusy and CYC_O, and return to IDLE.
REQ-026 ACK_I and ERR_I SHALL be ignored outside BUS.

Reset
REQ-027 Reset=1 at a rising edge SHALL force IDLE, in any state including mid-burst, with all of the following 0 from that edge: oBusy, oDone, oError, oMemWriteEnable, STB_O, CYC_O, WE_O, ADR_O, DAT_O, TGC_O, oMemReadAddr, oMemWriteAddr, oMemWriteData.
REQ-028 iStart asserted during reset SHALL be ignored.

Verification
REQ-029 Immediate write, COMPONENTS=3, iAdrImm=0x100, iMemAddr=4, rows=1, row4={Z=3,Y=2,X=1}, ACK_I tied high -> SHALL produce writes (0x100,1), (0x101,2), (0x102,3), then oDone one cycle after the third ACK; TGC_O=01.
REQ-030 Pointer read, row9 X=0x2000, iMemAddr=10, rows=2, DAT_I=0xA..0xF on successive ACKs -> SHALL read from bus addresses 0x2000-0x2005, write row10={0xC,0xB,0xA} and row11={0xF,0xE,0xD}, with oMemWriteEnable high for two separate cycles.
REQ-031 iRowCount=0 -> SHALL pulse oDone one cycle after the start, with STB_O and CYC_O never high.
REQ-032 ERR_I on the second word of a read -> SHALL assert oError, never assert oMemWriteEnable, pulse oDone, and return CYC_O to 0.
REQ-033 Reset asserted mid-burst with ACK_I stalled low -> all outputs SHALL be 0 next cycle; a new iStart SHALL then complete normally.
REQ-034 iAdrImm=0xFFFFFFFF, rows=1 -> SHALL use bus addresses 0xFFFFFFFF, 0x0, 0x1; iStart pulsed while busy SHALL have no effect.
